// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA timing generator with registered pixel output stage
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int COLOR_BITS = 1,
  parameter int CNT_W      = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    pix_en,
  input  logic                    test_pattern,
  input  logic [3*COLOR_BITS-1:0] rgb_in,
  output logic [CNT_W-1:0]        xpix,
  output logic [CNT_W-1:0]        ypix,
  output logic                    hsync,
  output logic                    vsync,
  output logic                    de,
  output logic [COLOR_BITS-1:0]   red,
  output logic [COLOR_BITS-1:0]   green,
  output logic [COLOR_BITS-1:0]   blue,
  output logic                    line_start,
  output logic                    frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int BAR_W   = H_VISIBLE / 8;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);

  logic [CNT_W-1:0]        h_cnt;
  logic [CNT_W-1:0]        v_cnt;
  logic [CNT_W-1:0]        bar_sub;
  logic [2:0]              bar_idx;
  logic                    h_wrap;
  logic                    v_wrap;
  logic                    hs_act;
  logic                    vs_act;
  logic                    visible;
  logic [2:0]              bar_code;
  logic [3*COLOR_BITS-1:0] bar_rgb;
  logic [3*COLOR_BITS-1:0] pix_rgb;

  assign h_wrap = (h_cnt == H_LAST);
  assign v_wrap = (v_cnt == V_LAST);

  // The request coordinate is the live counter, so the frame logic sees it a cycle ahead of the pins.
  assign xpix = h_cnt;
  assign ypix = v_cnt;

  // Raster counters: h runs every enabled pixel, v steps on each h wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        h_cnt <= '0;
        v_cnt <= v_wrap ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Bar tracker follows h_cnt so the bar index is ready without dividing h_cnt by the bar width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_sub <= '0;
      bar_idx <= '0;
    end else if (pix_en) begin
      if (h_wrap) begin
        bar_sub <= '0;
        bar_idx <= '0;
      end else if (bar_sub == BAR_LAST) begin
        bar_sub <= '0;
        bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_sub <= bar_sub + 1'b1;
      end
    end
  end

  // Region decode and colour selection for the pixel the counters currently point at.
  always_comb begin
    hs_act   = 1'b0;
    vs_act   = 1'b0;
    visible  = 1'b0;
    bar_code = 3'd0;
    bar_rgb  = '0;
    pix_rgb  = '0;

    hs_act   = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
    vs_act   = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);
    visible  = (h_cnt < H_VIS) && (v_cnt < V_VIS);

    // Bars run white to black, so the code is the bit-inverse of the bar index.
    bar_code = ~bar_idx;
    bar_rgb  = {{COLOR_BITS{bar_code[2]}}, {COLOR_BITS{bar_code[1]}}, {COLOR_BITS{bar_code[0]}}};

    if (visible) begin
      pix_rgb = test_pattern ? bar_rgb : rgb_in;
    end
  end

  // Output stage: everything sent to the pins is registered together so sync, de and colour stay aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      de          <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hsync              <= hs_act ? HSYNC_POL : ~HSYNC_POL;
      vsync              <= vs_act ? VSYNC_POL : ~VSYNC_POL;
      de                 <= visible;
      {red, green, blue} <= pix_rgb;
      line_start         <= (h_cnt == '0);
      frame_start        <= (h_cnt == '0) && (v_cnt == '0);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - randomized bench for vga_timing_gen against a raster arithmetic model
module tb_vga_timing_gen;

  // Small geometry instance so whole frames fit in a short run; default instance covers the first lines.
  localparam int SHV = 32, SHF = 4, SHS = 6, SHB = 6;
  localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;
  localparam int SCB = 2,  SCW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic pix_en = 1'b0;
  logic test_pattern = 1'b0;

  logic [2:0] d_rgb_in = '0;
  logic [9:0] d_xpix, d_ypix;
  logic       d_hsync, d_vsync, d_de, d_red, d_green, d_blue, d_line_start, d_frame_start;

  logic [5:0] s_rgb_in = '0;
  logic [5:0] s_xpix, s_ypix;
  logic       s_hsync, s_vsync, s_de, s_line_start, s_frame_start;
  logic [1:0] s_red, s_green, s_blue;

  int checks = 0;
  int failures = 0;

  int          p_d = 0, p_s = 0;
  logic [16:0] exp_d, exp_s;

  always #5 clk = ~clk;

  vga_timing_gen u_dflt (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .test_pattern(test_pattern), .rgb_in(d_rgb_in),
    .xpix(d_xpix), .ypix(d_ypix), .hsync(d_hsync), .vsync(d_vsync), .de(d_de),
    .red(d_red), .green(d_green), .blue(d_blue),
    .line_start(d_line_start), .frame_start(d_frame_start)
  );

  vga_timing_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b0), .COLOR_BITS(SCB), .CNT_W(SCW)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .test_pattern(test_pattern), .rgb_in(s_rgb_in),
    .xpix(s_xpix), .ypix(s_ypix), .hsync(s_hsync), .vsync(s_vsync), .de(s_de),
    .red(s_red), .green(s_green), .blue(s_blue),
    .line_start(s_line_start), .frame_start(s_frame_start)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Expected registered outputs for pixel index p counted from (0,0); packed {hs,vs,de,ls,fs,colour[11:0]}.
  function automatic logic [16:0] model_out(input int p, input int hv, input int hf, input int hs, input int hb,
                                            input int vv, input int vf, input int vs, input int vb,
                                            input bit hpol, input bit vpol, input int cb,
                                            input bit tp, input logic [11:0] rgb);
    int ht, vt, x, y, full, code, col;
    bit on, hact, vact;
    logic [16:0] r;
    ht   = hv + hf + hs + hb;
    vt   = vv + vf + vs + vb;
    x    = p % ht;
    y    = (p / ht) % vt;
    on   = (x < hv) && (y < vv);
    hact = (x >= hv + hf) && (x < hv + hf + hs);
    vact = (y >= vv + vf) && (y < vv + vf + vs);
    full = (1 << cb) - 1;
    col  = 0;
    if (on) begin
      if (tp) begin
        code = 7 - x / (hv / 8);
        col  = ((((code >> 2) & 1) != 0 ? full : 0) << (2 * cb))
             | ((((code >> 1) & 1) != 0 ? full : 0) << cb)
             | (((code & 1) != 0) ? full : 0);
      end else begin
        col = int'(rgb);
      end
    end
    r[16]   = hact ? hpol : ~hpol;
    r[15]   = vact ? vpol : ~vpol;
    r[14]   = on;
    r[13]   = (x == 0);
    r[12]   = (x == 0) && (y == 0);
    r[11:0] = col[11:0];
    return r;
  endfunction

  task automatic compare_inst(input string pfx, input logic [16:0] obs, input logic [16:0] exp,
                              input int xo, input int yo, input int xe, input int ye);
    check({pfx, ".xpix"}, xo, xe);
    check({pfx, ".ypix"}, yo, ye);
    check({pfx, ".hsync"}, 32'(obs[16]), 32'(exp[16]));
    check({pfx, ".vsync"}, 32'(obs[15]), 32'(exp[15]));
    check({pfx, ".de"}, 32'(obs[14]), 32'(exp[14]));
    check({pfx, ".line_start"}, 32'(obs[13]), 32'(exp[13]));
    check({pfx, ".frame_start"}, 32'(obs[12]), 32'(exp[12]));
    check({pfx, ".rgb"}, 32'(obs[11:0]), 32'(exp[11:0]));
  endtask

  task automatic compare_all();
    compare_inst("dflt", {d_hsync, d_vsync, d_de, d_line_start, d_frame_start, 9'b0, d_red, d_green, d_blue},
                 exp_d, int'(d_xpix), int'(d_ypix), p_d % 800, (p_d / 800) % 525);
    compare_inst("small", {s_hsync, s_vsync, s_de, s_line_start, s_frame_start, 6'b0, s_red, s_green, s_blue},
                 exp_s, int'(s_xpix), int'(s_ypix),
                 p_s % (SHV + SHF + SHS + SHB), (p_s / (SHV + SHF + SHS + SHB)) % (SVV + SVF + SVS + SVB));
  endtask

  // Check what the last edges produced, then drive the inputs the next edge samples.
  task automatic step(input bit en, input bit tp);
    @(negedge clk);
    compare_all();
    pix_en       = en;
    test_pattern = tp;
    d_rgb_in     = 3'($urandom);
    s_rgb_in     = 6'($urandom);
    if (en) begin
      exp_d = model_out(p_d, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 1, tp, {9'b0, d_rgb_in});
      exp_s = model_out(p_s, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1, 1'b0, SCB, tp, {6'b0, s_rgb_in});
      p_d++;
      p_s++;
    end
  endtask

  // Assert reset away from any clock edge, check it took effect at once, then release on a negedge.
  task automatic async_reset();
    #2;
    rst_n  = 1'b0;
    pix_en = 1'b0;
    p_d    = 0;
    p_s    = 0;
    exp_d  = {1'b1, 1'b1, 3'b000, 12'h000};
    exp_s  = {1'b0, 1'b1, 3'b000, 12'h000};
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bit tp;
    tp = 1'b0;
    async_reset();

    // First line of the default raster with colour bars: bar edges, hsync window, first small frames.
    for (int i = 0; i < 900; i++) step(1'b1, 1'b1);

    // Irregular pixel enable with occasional pattern toggles.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 15) == 0) tp = ~tp;
      step($urandom_range(0, 3) != 0, tp);
    end

    // Reset in the middle of a line, then restart from (0,0).
    async_reset();
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0);
    @(negedge clk);
    compare_all();
    async_reset();

    // Per-pixel pattern switching at full rate.
    for (int i = 0; i < 1700; i++) step(1'b1, $urandom_range(0, 1) == 1);
    @(negedge clk);
    compare_all();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA timing generator and pixel output stage. Successor to the fixed 640x480, 1-bit-colour controller.
- Produces hsync/vsync, data-enable, pixel request coordinates and registered RGB.
- Adds configurable geometry and sync polarity, multi-bit colour, a pixel clock enable, line/frame strobes and a built-in colour-bar test pattern.
- Sits between the game/frame logic, which supplies pixel colour for the requested coordinate, and the board VGA pins.

Parameters:
H_VISIBLE, 640, visible pixels per line (must be divisible by 8)
H_FRONT, 16, horizontal front porch, pixels
H_SYNC, 96, horizontal sync width, pixels
H_BACK, 48, horizontal back porch, pixels
V_VISIBLE, 480, visible lines per frame
V_FRONT, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BACK, 33, vertical back porch, lines
HSYNC_POL, 0, active level of hsync
VSYNC_POL, 0, active level of vsync
COLOR_BITS, 1, bits per colour channel
CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
pix_en  in  1  pixel clock enable; all state advances only on clk edges with pix_en=1
test_pattern  in  1  1 = output colour bars instead of rgb_in
rgb_in  in  3*COLOR_BITS  {r,g,b} colour for the current xpix/ypix, valid in the same cycle
xpix  out  CNT_W  current horizontal counter (request coordinate), combinational from counter
ypix  out  CNT_W  current vertical counter, combinational from counter
hsync  out  1  registered horizontal sync
vsync  out  1  registered vertical sync
de  out  1  registered data enable (visible region)
red  out  COLOR_BITS  registered red
green  out  COLOR_BITS  registered green
blue  out  COLOR_BITS  registered blue
line_start  out  1  registered strobe, pixel 0 of every line
frame_start  out  1  registered strobe, pixel (0,0)

Behaviour:
- H_TOTAL = sum of the four H_* parameters (800 by default). V_TOTAL = sum of the four V_* parameters (525 by default).
- Reset (async, immediate, no clock needed):
  - h_cnt = v_cnt = 0, bar state = 0.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - de, red, green, blue, line_start, frame_start all 0.
- Counters, on an enabled edge:
  - h_cnt increments and wraps at H_TOTAL-1 to 0.
  - On the h wrap, v_cnt increments and wraps at V_TOTAL-1 to 0.
  - pix_en=0: everything holds, including outputs.
- Output stage:
  - Registered on enabled edges from the pre-increment counter values, giving 1 enabled-cycle latency versus xpix/ypix.
  - rgb_in is sampled on the same edge, so colour stays aligned with the coordinate that requested it.
- hsync active when h_cnt is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC). Default range: 656..751.
- vsync active when v_cnt is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC). Default range: 490..491.
- de = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- Colour:
  - de=0: red = green = blue = 0, regardless of rgb_in or test_pattern.
  - de=1 and test_pattern=0: {red,green,blue} = rgb_in.
  - de=1 and test_pattern=1: 8 vertical bars, each H_VISIBLE/8 pixels wide. Bar k (k = 0..7) has 3-bit code {r,g,b} = 7-k, and each bit is replicated across COLOR_BITS.
- Bar index implementation:
  - Tracked with an incremental sub-counter; no divider.
  - Sub-counter and bar index reset at h_cnt=0.
  - Bar index increments when the sub-counter reaches H_VISIBLE/8-1.
- test_pattern is sampled per pixel; toggling mid-line takes effect on the next enabled edge.
- line_start = (h_cnt==0). frame_start = (h_cnt==0 && v_cnt==0). Each is high for exactly one pixel period, i.e. until the next enabled edge.
- Release of rst_n: the first enabled edge outputs pixel (0,0), with de=1, line_start=1 and frame_start=1.
- Reset asserted mid-frame: immediate return to reset values; counting restarts at (0,0).

Test Plan:
- Reset: with rst_n=0 and clk stopped, check hsync=1, vsync=1, de=0, rgb=0, xpix=ypix=0. Assert rst_n mid-line at xpix=300 → outputs return to reset values with no clk edge.
- H timing, defaults, pix_en=1 constantly: hsync low for outputs after enabled edges 657..752 (96 cycles). de high for edges 1..640. line_start period = 800 clk.
- V timing: vsync low for exactly 1600 clk starting at output line 490. frame_start period = 420000 clk. pix_en toggling every other clk → period 840000 clk and identical output sequence.
- Data path: rgb_in = xpix[2:0] in the visible region → output at pixel 5 is 3'b101, one enabled cycle after xpix=5. rgb_in=3'b111 during x=640..799 → rgb output 0.
- Test pattern: test_pattern=1 → pixel 0 = 111, pixel 79 = 111, pixel 80 = 110, pixel 559 = 001, pixel 560 = 000, pixel 639 = 000. Blanking stays 000.
- Parametrised build: H_VISIBLE=320, H_FRONT=8, H_SYNC=48, H_BACK=24, HSYNC_POL=1, COLOR_BITS=4 → H_TOTAL=400. hsync high for h_cnt 328..375. Bar 1 output = 12'hFF0.
